seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Sequential unsigned restoring divider; the inverse of the team's combinational 4-bit array multiplier.
- Accepts a dividend/divisor pair with a start handshake and iterates one quotient bit per clock.
- Returns quotient and remainder with a one-cycle done pulse.
- Serves as the division datapath block alongside the multiplier in the arithmetic unit.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (legal 2..16)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only when not busy
a  input  WIDTH  dividend, sampled at the accepting edge
b  input  WIDTH  divisor, sampled at the accepting edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: Q/R valid
Q  output  WIDTH  quotient
R  output  WIDTH  remainder
div_by_zero  output  1  high with done when b was 0; held until next accept

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk and rst.
- Reset values: state IDLE; busy=0, done=0, Q=0, R=0, div_by_zero=0; internal count=0.
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - DONE: one cycle, done=1.
- Accept: start=1 at a rising edge k while in IDLE or DONE.
  - Latch a into the quotient/shift register and b into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits) and div_by_zero.
  - Set count=WIDTH-1 and go to CALC.
  - busy=1 from edge k.
- Divide by zero: if b==0 at accept, skip CALC.
  - Go to DONE at edge k+1: Q=all ones, R=a, div_by_zero=1.
- CALC, each edge performs one restoring step:
  - Form {rem,qreg} shifted left by 1.
  - trial = rem_shifted - {1'b0,divisor}.
  - If trial is non-negative (MSB=0): rem=trial, quotient LSB=1. Otherwise keep rem, quotient LSB=0.
  - count decrements. The step executed with count==0 transitions to DONE.
- Latency: exactly WIDTH edges after the accepting edge. done=1 in the cycle following edge k+WIDTH; busy=0 in that same cycle.
- DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted (back-to-back allowed; done and accept may coincide).
- Q/R/div_by_zero hold their last values until the next completion.
  - Q/R update only on entry to DONE.
  - div_by_zero clears at accept.
- start while busy (CALC) is ignored; no queuing.
- rst asserted mid-operation aborts it: the next cycle shows reset values and no done pulse.
- Arithmetic invariant for b≠0: a == Q*b + R and R < b.
- No X propagation: a/b are not sampled outside accept.

Decomposition:
- Package seq_div_pkg:
  - state enum (IDLE, CALC, DONE) as a 2-bit typedef.
  - Localparam CNT_W = $clog2(WIDTH) for the counter width.
- Sub-module div_step:
  - Combinational single restoring iteration.
  - Inputs: rem, qreg, divisor.
  - Outputs: next_rem, next_qreg.
  - Instantiated once; the FSM/registers stay in seq_div.

Test Plan:
- a=13, b=3, start at edge k -> busy high from k; done pulse after edge k+4; Q=4, R=1, div_by_zero=0.
- a=7, b=0 -> done after edge k+1; Q=15, R=7, div_by_zero=1. A following a=8, b=2 gives Q=4, R=0 and div_by_zero=0.
- a=3, b=9 -> Q=0, R=3. Then a=15, b=1 -> Q=15, R=0.
- Start held high during CALC with different operands -> ignored; first result unchanged. A new accept occurs in the DONE cycle, so results come back-to-back every 5 cycles.
- rst asserted at edge k+2 of a 12/5 divide -> all outputs 0, no done pulse. A fresh 12/5 then returns Q=2, R=2.
- All 256 (a,b) pairs for WIDTH=4, back-to-back -> each result matches the a/b, a%b reference model (b=0 rule as above) with exact latency.

Source files
------------

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding and counter sizing for the sequential divider
package seq_div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int DEF_WIDTH = 4;
    localparam int CNT_W = $clog2(DEF_WIDTH);
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] qreg,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic [WIDTH-1:0] next_qreg
);
    logic [WIDTH+1:0] trial;
    logic             neg;
    // One extra bit keeps the sign of the trial subtraction unambiguous
    assign trial     = {rem, qreg[WIDTH-1]} - {2'b0, divisor};
    assign neg       = trial[WIDTH+1];
    assign next_rem  = neg ? {rem[WIDTH-1:0], qreg[WIDTH-1]} : trial[WIDTH:0];
    assign next_qreg = {qreg[WIDTH-2:0], ~neg};
endmodule

// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, one quotient bit per clock
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    state_t           state, state_n;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem, next_rem;
    logic [WIDTH-1:0] qreg, next_qreg, divisor;
    logic             accept, last;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .qreg     (qreg),
        .divisor  (divisor),
        .next_rem (next_rem),
        .next_qreg(next_qreg)
    );
    assign busy = state == CALC;
    assign done = state == DONE;
    always_comb begin
        accept  = start && state != CALC;
        last    = divisor == '0 || count == '0;
        state_n = state;
        if (accept)
            state_n = CALC;
        else if (state == CALC && last)
            state_n = DONE;
        else if (state == DONE)
            state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            qreg        <= '0;
            divisor     <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                qreg        <= a;
                divisor     <= b;
                rem         <= '0;
                div_by_zero <= 1'b0;
                count       <= CW'(WIDTH - 1);
            end else if (state == CALC) begin
                // A zero divisor short-circuits straight to the result
                if (divisor == '0) begin
                    Q           <= '1;
                    R           <= qreg;
                    div_by_zero <= 1'b1;
                end else begin
                    rem   <= next_rem;
                    qreg  <= next_qreg;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        Q <= next_qreg;
                        R <= next_rem[WIDTH-1:0];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized scoreboard bench for seq_div against a plain a/b, a%b model
module tb_seq_div;
    localparam int W = 4;
    logic         clk = 0, rst = 1, start = 0;
    logic [W-1:0] a = 0, b = 0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] Q, R;
    int           cyc = 0, tests = 0, fails = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           due;
    } exp_t;
    exp_t sb[$];
    exp_t e_m;

    seq_div #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .Q(Q), .R(R), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                e_m = sb.pop_front();
                check("Q", int'(Q), int'(e_m.q));
                check("R", int'(R), int'(e_m.r));
                check("div_by_zero", int'(div_by_zero), int'(e_m.z));
                check("latency", cyc, e_m.due);
                check("busy_at_done", int'(busy), 0);
            end
        end else if (sb.size() > 0 && cyc >= sb[0].due) begin
            check("missing_done", 0, 1);
            void'(sb.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle so a
    // following call issues back-to-back with the completion.
    task automatic run(input int av, input int bv, input bit hold);
        exp_t e;
        int   lat;
        lat   = (bv == 0) ? 1 : W;
        e.q   = (bv == 0) ? W'((1 << W) - 1) : W'(av / bv);
        e.r   = (bv == 0) ? W'(av) : W'(av % bv);
        e.z   = (bv == 0);
        e.due = cyc + 1 + lat;
        sb.push_back(e);
        start = 1; a = W'(av); b = W'(bv);
        @(negedge clk);
        check("busy_after_accept", int'(busy), 1);
        start = hold;
        a = W'($urandom); b = W'($urandom);
        repeat (lat) @(negedge clk);
        start = 0;
    endtask

    task automatic idle(input int n);
        start = 0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_Q", int'(Q), 0);
        check("rst_R", int'(R), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        rst = 0;
        idle(2);
        run(13, 3, 0); idle(2);
        run(7, 0, 0);  run(8, 2, 0); idle(1);
        run(3, 9, 0);  run(15, 1, 0); idle(3);
        run(6, 4, 1);  run(11, 2, 1); run(9, 3, 0); idle(2);
        start = 1; a = 12; b = 5;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        rst = 1;
        sb.delete();
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_Q", int'(Q), 0);
        check("abort_R", int'(R), 0);
        check("abort_dbz", int'(div_by_zero), 0);
        rst = 0;
        idle(6);
        run(12, 5, 0); idle(2);
        for (int i = 0; i < 256; i++) run(i >> 4, i & 15, 0);
        for (int i = 0; i < 60; i++) begin
            run(int'($urandom_range(15)), int'($urandom_range(15)), ($urandom & 1) == 1);
            if ($urandom_range(3) == 0) idle(int'($urandom_range(3)));
        end
        idle(W + 4);
        if (sb.size() != 0) check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
